// File: rtl/scan_pkg.sv
// scan_pkg: shared types and default sizing for the scan sequencer slice.
//   scan_state_t       : sequencer FSM state encoding
//   SCAN_NUM_CH_DEF    : default number of detector channels
//   SCAN_TIMEOUT_W_DEF : default width of the dwell timeout value
package scan_pkg;

  localparam int unsigned SCAN_NUM_CH_DEF    = 2;
  localparam int unsigned SCAN_TIMEOUT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CH  = 2'd1,
    COMPLETE = 2'd2
  } scan_state_t;

endpackage : scan_pkg

// File: rtl/scan_dwell_timer.sv
// scan_dwell_timer: saturating per-channel dwell counter.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the count this cycle (asserted whenever a channel is armed)
//   limit        : dwell limit in cycles; 0 disables expiry
//   expire       : high when count == limit-1 and limit != 0
// The count is 0 in the first cycle a channel is armed, so expire at count
// limit-1 gives the armed channel exactly 'limit' cycles before advancing.
module scan_dwell_timer
  import scan_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = SCAN_TIMEOUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expire
);

  logic [TIMEOUT_W-1:0] count;

  // Saturating up-counter with synchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  // Expiry compare against the live limit value.
  assign expire = (limit != '0) && (count == (limit - TIMEOUT_W'(1)));

endmodule : scan_dwell_timer

// File: rtl/scan_sequencer.sv
// scan_sequencer: one-hot multi-channel scan-cycle sequencer.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   sync_start     : scan sync level; a rising edge starts a scan
//   timeout_cycles : dwell limit per channel (0 = no timeout)
//   ch_detected    : per-channel detect; only the armed channel is observed
//   dir            : scan direction, toggles on every accepted scan start
//   ch_enable      : one-hot enable of the armed channel, or all zero
//   busy           : high while a scan is in progress
//   scan_done      : one-cycle pulse after the last channel finishes
//   timeout_flags  : bit k set if channel k timed out in the current/last scan
//   overrun        : one-cycle pulse on a sync rising edge while busy
// All outputs are registered.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned NUM_CH         = SCAN_NUM_CH_DEF,
  parameter int unsigned TIMEOUT_W      = SCAN_TIMEOUT_W_DEF,
  parameter bit          REVERSE_ON_DIR = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_start,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic [NUM_CH-1:0]    ch_detected,
  output logic                 dir,
  output logic [NUM_CH-1:0]    ch_enable,
  output logic                 busy,
  output logic                 scan_done,
  output logic [NUM_CH-1:0]    timeout_flags,
  output logic                 overrun
);

  localparam int unsigned         IDX_W    = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0]   ONE_HOT0 = NUM_CH'(1);

  scan_state_t      state;
  logic             sync_prev;
  logic             rev;
  logic [IDX_W-1:0] idx;

  logic             sync_rise;
  logic             det_hit;
  logic             expire;
  logic             last_ch;
  logic             start_scan;
  logic             advance;
  logic             timer_clear;
  logic             first_rev;
  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] next_idx;

  // Decode of the current cycle's events; no path from here reaches an output
  // except through the registers below.
  always_comb begin
    sync_rise   = sync_start & ~sync_prev;
    // ch_enable is one-hot on the armed channel, so masking isolates it.
    det_hit     = |(ch_detected & ch_enable);
    last_ch     = rev ? (idx == '0) : (idx == LAST_IDX);
    next_idx    = rev ? (idx - IDX_W'(1)) : (idx + IDX_W'(1));
    // Reverse order applies when the new direction (~dir) is 1.
    first_rev   = REVERSE_ON_DIR && !dir;
    first_idx   = first_rev ? LAST_IDX : '0;
    start_scan  = (state != WAIT_CH) && sync_rise;
    advance     = (state == WAIT_CH) && (det_hit || expire);
    timer_clear = start_scan || advance;
  end

  scan_dwell_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .limit   (timeout_cycles),
    .expire  (expire)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      sync_prev     <= 1'b0;
      rev           <= 1'b0;
      idx           <= '0;
      dir           <= 1'b0;
      ch_enable     <= '0;
      busy          <= 1'b0;
      scan_done     <= 1'b0;
      timeout_flags <= '0;
      overrun       <= 1'b0;
    end else begin
      sync_prev <= sync_start;
      scan_done <= 1'b0;
      overrun   <= 1'b0;

      case (state)
        IDLE, COMPLETE: begin
          if (sync_rise) begin
            dir           <= ~dir;
            timeout_flags <= '0;
            busy          <= 1'b1;
            rev           <= first_rev;
            idx           <= first_idx;
            ch_enable     <= ONE_HOT0 << first_idx;
            state         <= WAIT_CH;
          end
        end

        WAIT_CH: begin
          // A sync edge mid-scan is reported but otherwise ignored.
          if (sync_rise) begin
            overrun <= 1'b1;
          end
          if (advance) begin
            // Detect has priority over a coincident timeout.
            if (!det_hit) begin
              timeout_flags[idx] <= 1'b1;
            end
            if (last_ch) begin
              ch_enable <= '0;
              busy      <= 1'b0;
              scan_done <= 1'b1;
              state     <= COMPLETE;
            end else begin
              idx       <= next_idx;
              ch_enable <= ONE_HOT0 << next_idx;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : scan_sequencer

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed self-checking bench. Two 4-channel instances:
// dut_f visits channels in ascending order, dut_r reverses on dir=1 scans.
module tb_scan_sequencer;

  logic        clk;
  logic        reset_n;
  logic [15:0] timeout_cycles;
  logic        sync_f, sync_r;
  logic [3:0]  det_f, det_r;

  logic        dir_f, busy_f, done_f, ovr_f;
  logic [3:0]  en_f, flags_f;
  logic        dir_r, busy_r, done_r, ovr_r;
  logic [3:0]  en_r, flags_r;

  int checks   = 0;
  int failures = 0;
  logic [3:0] e;

  scan_sequencer #(.NUM_CH(4), .TIMEOUT_W(16), .REVERSE_ON_DIR(1'b0)) dut_f (
    .clk            (clk),
    .reset_n        (reset_n),
    .sync_start     (sync_f),
    .timeout_cycles (timeout_cycles),
    .ch_detected    (det_f),
    .dir            (dir_f),
    .ch_enable      (en_f),
    .busy           (busy_f),
    .scan_done      (done_f),
    .timeout_flags  (flags_f),
    .overrun        (ovr_f)
  );

  scan_sequencer #(.NUM_CH(4), .TIMEOUT_W(16), .REVERSE_ON_DIR(1'b1)) dut_r (
    .clk            (clk),
    .reset_n        (reset_n),
    .sync_start     (sync_r),
    .timeout_cycles (timeout_cycles),
    .ch_detected    (det_r),
    .dir            (dir_r),
    .ch_enable      (en_r),
    .busy           (busy_r),
    .scan_done      (done_r),
    .timeout_flags  (flags_r),
    .overrun        (ovr_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    sync_f = 1'b0; sync_r = 1'b0;
    det_f = '0; det_r = '0;
    timeout_cycles = 16'd0;
    tick(); tick();

    // Reset values
    chk1("rst_dir", dir_f, 1'b0);
    chk4("rst_en", en_f, 4'b0000);
    chk1("rst_busy", busy_f, 1'b0);
    chk1("rst_done", done_f, 1'b0);
    chk4("rst_flags", flags_f, 4'b0000);
    chk1("rst_ovr", ovr_f, 1'b0);
    reset_n = 1'b1;
    tick();
    chk4("idle_en", en_f, 4'b0000);

    // Scan 1: no timeout, each channel detected 3 cycles after arm
    sync_f = 1'b1;
    tick();
    chk1("s1_dir", dir_f, 1'b1);
    chk4("s1_en0", en_f, 4'b0001);
    chk1("s1_busy", busy_f, 1'b1);
    sync_f = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = 4'b0001 << k;
      tick(); tick();
      chk4("s1_hold", en_f, e);
      det_f = e;
      tick();
      det_f = '0;
      if (k < 3) chk4("s1_step", en_f, e << 1);
    end
    chk1("s1_done", done_f, 1'b1);
    chk1("s1_busy_lo", busy_f, 1'b0);
    chk4("s1_en_off", en_f, 4'b0000);
    chk1("s1_dir_keep", dir_f, 1'b1);
    tick();
    chk1("s1_done_lo", done_f, 1'b0);

    // Scan 2: timeout 5, ch1 never detects
    timeout_cycles = 16'd5;
    sync_f = 1'b1;
    tick();
    chk1("s2_dir", dir_f, 1'b0);
    chk4("s2_en0", en_f, 4'b0001);
    det_f = 4'b0001;
    tick();
    det_f = '0;
    for (int k = 0; k < 5; k++) begin
      chk4("s2_ch1_dwell", en_f, 4'b0010);
      tick();
    end
    chk4("s2_en2", en_f, 4'b0100);
    chk4("s2_flags", flags_f, 4'b0010);
    det_f = 4'b0100;
    tick();
    chk4("s2_en3", en_f, 4'b1000);
    det_f = 4'b1000;
    tick();
    det_f = '0;
    chk1("s2_done", done_f, 1'b1);
    chk4("s2_flags_keep", flags_f, 4'b0010);

    // Scan 3: new sync clears flags; detect and timeout coincide on ch0
    timeout_cycles = 16'd2;
    tick();
    sync_f = 1'b0;
    tick();
    sync_f = 1'b1;
    tick();
    chk4("s3_flags_clr", flags_f, 4'b0000);
    chk1("s3_dir", dir_f, 1'b1);
    chk4("s3_en0", en_f, 4'b0001);
    tick();
    det_f = 4'b0001;
    tick();
    det_f = '0;
    chk4("s3_en1", en_f, 4'b0010);
    chk4("s3_no_flag", flags_f, 4'b0000);
    tick(); tick();
    chk4("s3_en2", en_f, 4'b0100);
    chk4("s3_ch1_to", flags_f, 4'b0010);
    timeout_cycles = 16'd0;

    // Sync edge mid-scan
    sync_f = 1'b0;
    tick();
    sync_f = 1'b1;
    tick();
    chk1("ovr_pulse", ovr_f, 1'b1);
    chk1("ovr_dir", dir_f, 1'b1);
    chk4("ovr_en", en_f, 4'b0100);
    chk1("ovr_busy", busy_f, 1'b1);
    tick();
    chk1("ovr_lo", ovr_f, 1'b0);
    chk4("ovr_en_keep", en_f, 4'b0100);

    // Reset mid-scan with sync_start held high
    #2;
    reset_n = 1'b0;
    #1;
    chk4("mrst_en", en_f, 4'b0000);
    chk1("mrst_busy", busy_f, 1'b0);
    chk1("mrst_dir", dir_f, 1'b0);
    chk4("mrst_flags", flags_f, 4'b0000);
    tick();
    chk4("mrst_hold_en", en_f, 4'b0000);
    reset_n = 1'b1;
    tick();
    chk1("rel_dir", dir_f, 1'b1);
    chk4("rel_en", en_f, 4'b0001);
    chk1("rel_busy", busy_f, 1'b1);
    chk1("rel_ovr", ovr_f, 1'b0);

    // Reverse instance: first scan 3..0, second scan 0..3
    sync_r = 1'b1;
    tick();
    sync_r = 1'b0;
    chk1("r1_dir", dir_r, 1'b1);
    for (int k = 0; k < 4; k++) begin
      e = 4'b1000 >> k;
      chk4("r1_en", en_r, e);
      det_r = e;
      tick();
      det_r = '0;
    end
    chk1("r1_done", done_r, 1'b1);
    chk4("r1_en_off", en_r, 4'b0000);
    sync_r = 1'b1;
    tick();
    sync_r = 1'b0;
    chk1("r2_dir", dir_r, 1'b0);
    for (int k = 0; k < 4; k++) begin
      e = 4'b0001 << k;
      chk4("r2_en", en_r, e);
      det_r = e;
      tick();
      det_r = '0;
    end
    chk1("r2_done", done_r, 1'b1);
    chk1("r2_busy", busy_r, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_scan_sequencer
